// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: control-register map,
// MEM-stage control ops, exception codes, execution modes and FSM states.
package pipe_ctrl_pkg;

    localparam logic [4:0] CREG_STATUS     = 5'd0;
    localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
    localparam logic [4:0] CREG_INT_MASK   = 5'd2;
    localparam logic [4:0] CREG_EXP_VECTOR = 5'd3;
    localparam logic [4:0] CREG_CAUSE      = 5'd4;
    localparam logic [4:0] CREG_EPC        = 5'd5;

    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_WRCR = 2'd1,
        CTRL_OP_EXRT = 2'd2
    } ctrl_op_e;

    typedef enum logic [2:0] {
        ISA_EXP_NO_EXP     = 3'd0,
        ISA_EXP_EXT_INT    = 3'd1,
        ISA_EXP_UNDEF_INSN = 3'd2,
        ISA_EXP_OVERFLOW   = 3'd3,
        ISA_EXP_MISS_ALIGN = 3'd4,
        ISA_EXP_TRAP       = 3'd5,
        ISA_EXP_PRV_VIO    = 3'd6
    } isa_exp_e;

    localparam logic MODE_KERNEL = 1'b0;
    localparam logic MODE_USER   = 1'b1;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    // A delay-slot instruction must restart at its branch, one word earlier.
    function automatic logic [29:0] epc_of(input logic [29:0] pc, input logic br_flag);
        return br_flag ? (pc - 30'd1) : pc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_creg.sv
// Control-register file: combinational read mux, WRCR write decode and the
// exception / exception-return updates of STATUS, PRE_STATUS, CAUSE and EPC.
module pipe_ctrl_creg
    import pipe_ctrl_pkg::*;
#(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rd_addr_i,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [4:0]       wr_addr_i,
    input  logic [31:0]      wr_data_i,
    input  logic             exc_i,
    input  logic [2:0]       exc_code_i,
    input  logic             exc_br_flag_i,
    input  logic [29:0]      exc_pc_i,
    input  logic             exrt_i,
    output logic             int_en_o,
    output logic             mode_o,
    output logic [IRQ_W-1:0] int_mask_o,
    output logic [29:0]      exp_vector_o,
    output logic [29:0]      epc_o
);

    logic [1:0]       status_q,     status_d;
    logic [1:0]       pre_status_q, pre_status_d;
    logic [IRQ_W-1:0] int_mask_q,   int_mask_d;
    logic [29:0]      exp_vector_q, exp_vector_d;
    logic [3:0]       cause_q,      cause_d;
    logic [29:0]      epc_q,        epc_d;

    always_comb begin
        rd_data_o = '0;
        case (rd_addr_i)
            CREG_STATUS:     rd_data_o[1:0]       = status_q;
            CREG_PRE_STATUS: rd_data_o[1:0]       = pre_status_q;
            CREG_INT_MASK:   rd_data_o[IRQ_W-1:0] = int_mask_q;
            CREG_EXP_VECTOR: rd_data_o[29:0]      = exp_vector_q;
            CREG_CAUSE:      rd_data_o[3:0]       = cause_q;
            CREG_EPC:        rd_data_o[29:0]      = epc_q;
            default:         rd_data_o            = '0;
        endcase
    end

    always_comb begin
        status_d     = status_q;
        pre_status_d = pre_status_q;
        int_mask_d   = int_mask_q;
        exp_vector_d = exp_vector_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        // The caller guarantees exc_i, exrt_i and wr_en_i are mutually exclusive.
        if (exc_i) begin
            cause_d      = {exc_br_flag_i, exc_code_i};
            epc_d        = epc_of(exc_pc_i, exc_br_flag_i);
            pre_status_d = status_q;
            status_d     = {1'b0, MODE_KERNEL};
        end else if (exrt_i) begin
            status_d = pre_status_q;
        end else if (wr_en_i) begin
            case (wr_addr_i)
                CREG_STATUS:     status_d     = wr_data_i[1:0];
                CREG_PRE_STATUS: pre_status_d = wr_data_i[1:0];
                CREG_INT_MASK:   int_mask_d   = wr_data_i[IRQ_W-1:0];
                CREG_EXP_VECTOR: exp_vector_d = wr_data_i[29:0];
                CREG_CAUSE:      cause_d      = wr_data_i[3:0];
                CREG_EPC:        epc_d        = wr_data_i[29:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q     <= '0;
            pre_status_q <= '0;
            int_mask_q   <= '0;
            exp_vector_q <= '0;
            cause_q      <= '0;
            epc_q        <= '0;
        end else begin
            status_q     <= status_d;
            pre_status_q <= pre_status_d;
            int_mask_q   <= int_mask_d;
            exp_vector_q <= exp_vector_d;
            cause_q      <= cause_d;
            epc_q        <= epc_d;
        end
    end

    assign int_en_o     = status_q[1];
    assign mode_o       = status_q[0];
    assign int_mask_o   = int_mask_q;
    assign exp_vector_o = exp_vector_q;
    assign epc_o        = epc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage stall/flush generation, external
// interrupt detect and the IDLE/REDIRECT sequencer around exceptions.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int IRQ_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] irq,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ld_hazard,
    input  logic [4:0]       creg_rd_addr,
    output logic [31:0]      creg_rd_data,
    input  logic [29:0]      mem_pc,
    input  logic             mem_en,
    input  logic             mem_br_flag,
    input  logic [1:0]       mem_ctrl_op,
    input  logic [4:0]       mem_dst_addr,
    input  logic [31:0]      mem_out,
    input  logic [2:0]       mem_exp_code,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             int_detect,
    output logic [29:0]      new_pc,
    output logic             exe_mode
);

    state_e           state_q, state_d;
    logic             busy;
    logic             take_exc;
    logic             take_exrt;
    logic             take_wrcr;
    logic             int_en;
    logic [IRQ_W-1:0] int_mask;
    logic [29:0]      exp_vector;
    logic [29:0]      epc;

    assign busy      = if_busy | mem_busy;
    assign take_exc  = !busy && mem_en && (mem_exp_code != ISA_EXP_NO_EXP);
    assign take_exrt = !busy && mem_en && !take_exc && (mem_ctrl_op == CTRL_OP_EXRT);
    assign take_wrcr = !busy && mem_en && !take_exc && (mem_ctrl_op == CTRL_OP_WRCR);

    pipe_ctrl_creg #(.IRQ_W(IRQ_W)) u_creg (
        .clk           (clk),
        .reset         (reset),
        .rd_addr_i     (creg_rd_addr),
        .rd_data_o     (creg_rd_data),
        .wr_en_i       (take_wrcr),
        .wr_addr_i     (mem_dst_addr),
        .wr_data_i     (mem_out),
        .exc_i         (take_exc),
        .exc_code_i    (mem_exp_code),
        .exc_br_flag_i (mem_br_flag),
        .exc_pc_i      (mem_pc),
        .exrt_i        (take_exrt),
        .int_en_o      (int_en),
        .mode_o        (exe_mode),
        .int_mask_o    (int_mask),
        .exp_vector_o  (exp_vector),
        .epc_o         (epc)
    );

    always_comb begin
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        if_flush  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        new_pc    = '0;
        if (busy) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
        end else begin
            if (ld_hazard) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                id_flush = 1'b1;
            end
            if (take_exc || take_exrt) begin
                if_flush  = 1'b1;
                id_flush  = 1'b1;
                ex_flush  = 1'b1;
                mem_flush = 1'b1;
                new_pc    = take_exc ? exp_vector : epc;
            end
        end
    end

    always_comb begin
        state_d    = (take_exc || take_exrt) ? ST_REDIRECT : ST_IDLE;
        int_detect = int_en && (|(irq & int_mask)) && !busy
                     && (state_q == ST_IDLE) && !(take_exc || take_exrt);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset state, stall/flush priority, exception
// entry/return, interrupt detection and reset while redirecting.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic        if_busy, mem_busy, ld_hazard;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_out;
    logic [2:0]  mem_exp_code;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic        int_detect;
    logic [29:0] new_pc;
    logic        exe_mode;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sf;
    assign sf = {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush};

    pipe_ctrl #(.IRQ_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .if_busy      (if_busy),
        .mem_busy     (mem_busy),
        .ld_hazard    (ld_hazard),
        .creg_rd_addr (creg_rd_addr),
        .creg_rd_data (creg_rd_data),
        .mem_pc       (mem_pc),
        .mem_en       (mem_en),
        .mem_br_flag  (mem_br_flag),
        .mem_ctrl_op  (mem_ctrl_op),
        .mem_dst_addr (mem_dst_addr),
        .mem_out      (mem_out),
        .mem_exp_code (mem_exp_code),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .ex_stall     (ex_stall),
        .mem_stall    (mem_stall),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .ex_flush     (ex_flush),
        .mem_flush    (mem_flush),
        .int_detect   (int_detect),
        .new_pc       (new_pc),
        .exe_mode     (exe_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        irq = 8'h00; if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
        creg_rd_addr = 5'd0; mem_pc = '0; mem_en = 1'b0; mem_br_flag = 1'b0;
        mem_ctrl_op = 2'd0; mem_dst_addr = 5'd0; mem_out = '0; mem_exp_code = 3'd0;
    endtask

    task automatic wrcr(input logic [4:0] addr, input logic [31:0] data);
        mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = addr; mem_out = data;
        tick();
        mem_en = 1'b0; mem_ctrl_op = 2'd0; mem_dst_addr = 5'd0; mem_out = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 6; a++) begin
            creg_rd_addr = 5'(a); #1;
            n_cmp++; if (creg_rd_data !== 32'h0) begin n_err++; $display("FAIL reset_creg[%0d] got %h want %h", a, creg_rd_data, 32'h0); end
        end
        n_cmp++; if (sf !== 8'h00) begin n_err++; $display("FAIL reset_stall_flush got %b want %b", sf, 8'h00); end
        n_cmp++; if (int_detect !== 1'b0) begin n_err++; $display("FAIL reset_int_detect got %b want 0", int_detect); end
        n_cmp++; if (new_pc !== 30'h0) begin n_err++; $display("FAIL reset_new_pc got %h want 0", new_pc); end
    endtask

    task automatic test_busy_priority();
        mem_busy = 1'b1; ld_hazard = 1'b1; mem_en = 1'b1; mem_exp_code = 3'd3; #1;
        n_cmp++; if (sf !== 8'b1111_0000) begin n_err++; $display("FAIL busy_hold got %b want %b", sf, 8'b1111_0000); end
        mem_busy = 1'b0; #1;
        n_cmp++; if (sf !== 8'b1100_1111) begin n_err++; $display("FAIL busy_release got %b want %b", sf, 8'b1100_1111); end
        n_cmp++; if (new_pc !== 30'h0) begin n_err++; $display("FAIL busy_release_pc got %h want 0", new_pc); end
        tick();
        idle_inputs();
        creg_rd_addr = 5'd4; #1;
        n_cmp++; if (creg_rd_data !== 32'h3) begin n_err++; $display("FAIL busy_cause got %h want 3", creg_rd_data); end
    endtask

    task automatic test_exception();
        wrcr(5'd3, 32'h100);
        mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd0; mem_out = 32'h2;
        creg_rd_addr = 5'd0; #1;
        n_cmp++; if (creg_rd_data !== 32'h0) begin n_err++; $display("FAIL no_bypass got %h want 0", creg_rd_data); end
        tick();
        idle_inputs();
        creg_rd_addr = 5'd3; #1;
        n_cmp++; if (creg_rd_data !== 32'h100) begin n_err++; $display("FAIL exp_vector got %h want 100", creg_rd_data); end
        mem_en = 1'b1; mem_exp_code = 3'd3; mem_pc = 30'h40; mem_br_flag = 1'b1; #1;
        n_cmp++; if (new_pc !== 30'h100) begin n_err++; $display("FAIL exc_new_pc got %h want 100", new_pc); end
        n_cmp++; if (sf !== 8'b0000_1111) begin n_err++; $display("FAIL exc_flush got %b want %b", sf, 8'b0000_1111); end
        tick();
        idle_inputs(); #1;
        n_cmp++; if (sf !== 8'h00) begin n_err++; $display("FAIL redirect_flush got %b want 0", sf); end
        creg_rd_addr = 5'd4; #1;
        n_cmp++; if (creg_rd_data !== 32'hB) begin n_err++; $display("FAIL exc_cause got %h want b", creg_rd_data); end
        creg_rd_addr = 5'd5; #1;
        n_cmp++; if (creg_rd_data !== 32'h3F) begin n_err++; $display("FAIL exc_epc got %h want 3f", creg_rd_data); end
        creg_rd_addr = 5'd0; #1;
        n_cmp++; if (creg_rd_data !== 32'h0) begin n_err++; $display("FAIL exc_status got %h want 0", creg_rd_data); end
        creg_rd_addr = 5'd1; #1;
        n_cmp++; if (creg_rd_data !== 32'h2) begin n_err++; $display("FAIL exc_pre_status got %h want 2", creg_rd_data); end
    endtask

    task automatic test_exrt();
        mem_en = 1'b1; mem_ctrl_op = 2'd2; #1;
        n_cmp++; if (new_pc !== 30'h3F) begin n_err++; $display("FAIL exrt_new_pc got %h want 3f", new_pc); end
        n_cmp++; if (sf !== 8'b0000_1111) begin n_err++; $display("FAIL exrt_flush got %b want %b", sf, 8'b0000_1111); end
        tick();
        idle_inputs();
        creg_rd_addr = 5'd0; #1;
        n_cmp++; if (creg_rd_data !== 32'h2) begin n_err++; $display("FAIL exrt_status got %h want 2", creg_rd_data); end
    endtask

    task automatic test_int_detect();
        wrcr(5'd2, 32'h04);
        irq = 8'h04; #1;
        n_cmp++; if (int_detect !== 1'b1) begin n_err++; $display("FAIL int_match got %b want 1", int_detect); end
        irq = 8'h02; #1;
        n_cmp++; if (int_detect !== 1'b0) begin n_err++; $display("FAIL int_masked got %b want 0", int_detect); end
        irq = 8'h04; if_busy = 1'b1; #1;
        n_cmp++; if (int_detect !== 1'b0) begin n_err++; $display("FAIL int_busy got %b want 0", int_detect); end
        if_busy = 1'b0;
        mem_en = 1'b1; mem_ctrl_op = 2'd2; #1;
        n_cmp++; if (int_detect !== 1'b0) begin n_err++; $display("FAIL int_exrt_cycle got %b want 0", int_detect); end
        tick();
        mem_en = 1'b0; mem_ctrl_op = 2'd0; #1;
        n_cmp++; if (int_detect !== 1'b0) begin n_err++; $display("FAIL int_redirect got %b want 0", int_detect); end
        tick();
        n_cmp++; if (int_detect !== 1'b1) begin n_err++; $display("FAIL int_back_idle got %b want 1", int_detect); end
        mem_en = 1'b1; mem_exp_code = 3'd5; #1;
        n_cmp++; if (int_detect !== 1'b0) begin n_err++; $display("FAIL int_exc_cycle got %b want 0", int_detect); end
        tick();
        mem_exp_code = 3'd6; #1;
        n_cmp++; if (sf !== 8'b0000_1111) begin n_err++; $display("FAIL exc_in_redirect got %b want %b", sf, 8'b0000_1111); end
        tick();
        idle_inputs();
        creg_rd_addr = 5'd4; #1;
        n_cmp++; if (creg_rd_data !== 32'h6) begin n_err++; $display("FAIL redirect_exc_cause got %h want 6", creg_rd_data); end
    endtask

    task automatic test_ld_hazard();
        tick();
        ld_hazard = 1'b1; #1;
        n_cmp++; if (sf !== 8'b1100_0100) begin n_err++; $display("FAIL ld_hazard got %b want %b", sf, 8'b1100_0100); end
        ld_hazard = 1'b0;
    endtask

    task automatic test_reset_mid();
        wrcr(5'd0, 32'h3);
        #1;
        n_cmp++; if (exe_mode !== 1'b1) begin n_err++; $display("FAIL exe_mode_user got %b want 1", exe_mode); end
        mem_en = 1'b1; mem_exp_code = 3'd4; mem_pc = 30'h55;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 6; a++) begin
            creg_rd_addr = 5'(a); #1;
            n_cmp++; if (creg_rd_data !== 32'h0) begin n_err++; $display("FAIL midreset_creg[%0d] got %h want 0", a, creg_rd_data); end
        end
        n_cmp++; if (sf !== 8'h00) begin n_err++; $display("FAIL midreset_stall_flush got %b want 0", sf); end
        n_cmp++; if (exe_mode !== 1'b0) begin n_err++; $display("FAIL midreset_mode got %b want 0", exe_mode); end
        wrcr(5'd7, 32'hFFFF_FFFF);
        creg_rd_addr = 5'd7; #1;
        n_cmp++; if (creg_rd_data !== 32'h0) begin n_err++; $display("FAIL unmapped_read got %h want 0", creg_rd_data); end
    endtask

    initial begin
        test_reset();
        test_busy_priority();
        test_exception();
        test_exrt();
        test_int_detect();
        test_ld_hazard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
